// File: rtl/fir_decimate_out.sv
// Decimating output stage for the 32-tap FIR: keep/round/saturate, then FIFO to a valid/ready port.
// Define FIR_DEC_ACCUM_EN for integrate-and-dump decimation instead of sample picking.
module fir_decimate_out #(
  parameter int unsigned IN_W       = 17,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned SHIFT      = 9,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [IN_W-1:0]               in_data,
  input  logic                          in_valid,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count
);

  localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
`ifdef FIR_DEC_ACCUM_EN
  localparam int unsigned SUM_W = IN_W + $clog2(DECIM);
`else
  localparam int unsigned SUM_W = IN_W;
`endif
  localparam logic [SUM_W:0] RND =
    (SUM_W+1)'((SHIFT == 0) ? 0 : (1 << ((SHIFT == 0) ? 0 : SHIFT - 1)));

  logic [PH_W-1:0]  phase;
  logic             last;
  logic             keep;
  logic [SUM_W-1:0] dump;
  logic [SUM_W:0]   rounded;
  logic [SUM_W:0]   y;
  logic [OUT_W-1:0] scaled;
  logic             sc_valid;
  logic [OUT_W-1:0] sc_data;

  assign last = (phase == PH_W'(DECIM - 1));
  assign keep = in_valid && last;

  always_ff @(posedge clock) begin
    if (!reset)
      phase <= '0;
    else if (in_valid)
      phase <= last ? '0 : phase + 1'b1;
  end

`ifdef FIR_DEC_ACCUM_EN
  logic [SUM_W-1:0] acc;

  // The dumped value includes the current sample, so the register restarts at 0.
  always_ff @(posedge clock) begin
    if (!reset)
      acc <= '0;
    else if (in_valid)
      acc <= last ? '0 : acc + SUM_W'(in_data);
  end

  assign dump = acc + SUM_W'(in_data);
`else
  assign dump = in_data;
`endif

  always_comb begin
    rounded = {1'b0, dump} + RND;
    y       = rounded >> SHIFT;
    scaled  = y[OUT_W-1:0];
    if ((y >> OUT_W) != '0)
      scaled = '1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sc_valid <= 1'b0;
      sc_data  <= '0;
    end else begin
      sc_valid <= keep;
      if (keep)
        sc_data <= scaled;
    end
  end

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  // Extra MSB on the pointers separates full from empty.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && out_ready;
  assign push  = sc_valid && (!full || pop);
  assign drop  = sc_valid && full && !pop;

  always_ff @(posedge clock) begin
    if (reset && push)
      mem[wptr[AW-1:0]] <= sc_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr       <= '0;
      rptr       <= '0;
      drop_count <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (drop && (drop_count != '1))
        drop_count <= drop_count + 1'b1;
    end
  end

  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : mem[rptr[AW-1:0]];
  assign fifo_level = wptr - rptr;

endmodule
